if_fetch_controller: RTL

//  Sequences the IF stage: owns the PC and drives the instruction-memory address.

---
 rtl/if_fetch_controller.sv | 114 +++++++++++
 1 files changed

// File: rtl/if_fetch_controller.sv
// IF-stage sequencer: owns the PC, drives the instruction-memory address and fills the IF/ID register.
// Optional feature: define PC_BOUND_CHECK_EN to halt fetch once the PC reaches PC_LIMIT.
module if_fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_LIMIT = 32'h0000_001C
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  input  logic        flush,
  input  logic        halt_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        valid_out,
  output logic        halted
);

  localparam int unsigned XLEN = 32;

`ifdef PC_BOUND_CHECK_EN
  localparam bit BOUND_EN = 1'b1;
`else
  localparam bit BOUND_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t            state, state_d;
  logic [XLEN-1:0]   pc, pc_d;
  logic [XLEN-1:0]   pc_out_d, instr_out_d;
  logic              valid_d;
  logic [XLEN-1:0]   pc_inc;
  logic [XLEN-1:0]   target;
  logic              bound_hit;

  assign pc_inc    = pc + XLEN'(4);
  assign target    = {branch_addr[XLEN-1:2], 2'b00};
  assign bound_hit = BOUND_EN && (pc >= PC_LIMIT);
  assign imem_addr = pc;
  assign halted    = (state == S_HALT);

  // State, PC and IF/ID register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_BOOT;
      pc        <= RESET_PC;
      pc_out    <= '0;
      instr_out <= '0;
      valid_out <= 1'b0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      pc_out    <= pc_out_d;
      instr_out <= instr_out_d;
      valid_out <= valid_d;
    end
  end

  // Next state and next register values; priority halt > branch > freeze > flush > fetch
  always_comb begin
    state_d     = state;
    pc_d        = pc;
    pc_out_d    = pc_out;
    instr_out_d = instr_out;
    valid_d     = valid_out;
    unique case (state)
      S_BOOT: begin
        state_d = S_RUN;
        if (branch_taken) begin
          pc_d    = target;
          valid_d = 1'b0;
        end
      end
      S_RUN, S_HOLD: begin
        if (halt_req || (bound_hit && !branch_taken)) begin
          state_d = S_HALT;
          valid_d = 1'b0;
        end else if (branch_taken) begin
          state_d = S_RUN;
          pc_d    = target;
          valid_d = 1'b0;
        end else if (freeze) begin
          state_d = S_HOLD;
        end else begin
          state_d = S_RUN;
          pc_d    = pc_inc;
          if (flush) begin
            valid_d = 1'b0;
          end else begin
            pc_out_d    = pc_inc;
            instr_out_d = imem_instr;
            valid_d     = 1'b1;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

endmodule
